// File: rtl/keypad_entry_if.sv
// Keypad entry bundle: scanner reports in, operand/sequencing state out.
// slave = keypad_entry_ctrl side, master = scanner/consumer side.
interface keypad_entry_if #(
    parameter int N_DIGITS = 3
) ();
    localparam int W     = 4 * N_DIGITS;
    localparam int LEN_W = $clog2(N_DIGITS + 1);

    logic             key_valid;
    logic [1:0]       key_row;
    logic [1:0]       key_col;
    logic [W-1:0]     entry_bcd;
    logic [LEN_W-1:0] entry_len;
    logic [W-1:0]     op_a;
    logic [W-1:0]     op_b;
    logic             op_sel;
    logic [1:0]       phase;
    logic             start;

    modport slave (
        input  key_valid, key_row, key_col,
        output entry_bcd, entry_len, op_a, op_b, op_sel, phase, start
    );

    modport master (
        output key_valid, key_row, key_col,
        input  entry_bcd, entry_len, op_a, op_b, op_sel, phase, start
    );
endinterface

// File: rtl/keypad_entry_ctrl.sv
// Keypad press detector and two-operand BCD entry sequencer for the calculator datapath.
// Optional feature macro SUB_OP_EN: key B acts as the subtract operator.
//
// state     | meaning
// S_ENTER_A | collecting operand A digits, waiting for an operator
// S_ENTER_B | collecting operand B digits, waiting for '#'
// S_DONE    | operands presented; next digit starts a new calculation
// S_BAD     | unreachable encoding, recovers to S_ENTER_A
module keypad_entry_ctrl #(
    parameter int N_DIGITS       = 3,
    parameter int RELEASE_CYCLES = 500_000
) (
    input  logic            clk,
    input  logic            rst_n,
    keypad_entry_if.slave   kif
);
    localparam int W     = 4 * N_DIGITS;
    localparam int LEN_W = $clog2(N_DIGITS + 1);
    localparam int CNT_W = $clog2(RELEASE_CYCLES);
    localparam logic [CNT_W-1:0] CNT_TC = CNT_W'(RELEASE_CYCLES - 1);

    typedef enum logic [1:0] {
        S_ENTER_A = 2'd0,
        S_ENTER_B = 2'd1,
        S_DONE    = 2'd2,
        S_BAD     = 2'd3
    } state_e;

    state_e           state_q, state_d;
    logic             held_q, held_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             ev_q, ev_d;
    logic [3:0]       code_q, code_d;
    logic [W-1:0]     entry_bcd_q, entry_bcd_d;
    logic [LEN_W-1:0] entry_len_q, entry_len_d;
    logic [W-1:0]     op_a_q, op_a_d;
    logic [W-1:0]     op_b_q, op_b_d;
    logic             op_sel_q, op_sel_d;
    logic             start_q, start_d;

    logic             is_digit, is_op, is_clr, is_eq, op_val;
    logic [3:0]       digit;
    logic [W-1:0]     shifted;
    logic             can_add, has_digits;

    // One event per press: a report while already held only re-arms the release timer.
    always_comb begin
        held_d = held_q;
        cnt_d  = cnt_q;
        ev_d   = 1'b0;
        code_d = code_q;
        if (kif.key_valid) begin
            cnt_d = '0;
            if (!held_q) begin
                ev_d   = 1'b1;
                held_d = 1'b1;
                code_d = {kif.key_row, kif.key_col};
            end
        end else if (held_q) begin
            if (cnt_q == CNT_TC) begin
                held_d = 1'b0;
                cnt_d  = '0;
            end else begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end
    end

    // Key code is {row, col}.
    always_comb begin
        is_digit = 1'b0;
        digit    = 4'd0;
        is_op    = 1'b0;
        op_val   = 1'b0;
        is_clr   = 1'b0;
        is_eq    = 1'b0;
        case (code_q)
            4'd0:  begin is_digit = 1'b1; digit = 4'd1; end
            4'd1:  begin is_digit = 1'b1; digit = 4'd2; end
            4'd2:  begin is_digit = 1'b1; digit = 4'd3; end
            4'd3:  is_op = 1'b1;
            4'd4:  begin is_digit = 1'b1; digit = 4'd4; end
            4'd5:  begin is_digit = 1'b1; digit = 4'd5; end
            4'd6:  begin is_digit = 1'b1; digit = 4'd6; end
`ifdef SUB_OP_EN
            4'd7:  begin is_op = 1'b1; op_val = 1'b1; end
`endif
            4'd8:  begin is_digit = 1'b1; digit = 4'd7; end
            4'd9:  begin is_digit = 1'b1; digit = 4'd8; end
            4'd10: begin is_digit = 1'b1; digit = 4'd9; end
            4'd12: is_clr = 1'b1;
            4'd13: begin is_digit = 1'b1; digit = 4'd0; end
            4'd14: is_eq = 1'b1;
            default: ;
        endcase
    end

    assign shifted    = {entry_bcd_q[W-5:0], digit};
    assign can_add    = entry_len_q < LEN_W'(N_DIGITS);
    assign has_digits = entry_len_q != '0;

    always_comb begin
        state_d     = state_q;
        entry_bcd_d = entry_bcd_q;
        entry_len_d = entry_len_q;
        op_a_d      = op_a_q;
        op_b_d      = op_b_q;
        op_sel_d    = op_sel_q;
        start_d     = 1'b0;
        if (state_q == S_BAD) begin
            state_d     = S_ENTER_A;
            entry_bcd_d = '0;
            entry_len_d = '0;
        end else if (ev_q && is_clr) begin
            state_d     = S_ENTER_A;
            entry_bcd_d = '0;
            entry_len_d = '0;
            op_a_d      = '0;
            op_b_d      = '0;
            op_sel_d    = 1'b0;
        end else if (ev_q) begin
            case (state_q)
                S_ENTER_A, S_ENTER_B: begin
                    if (is_digit) begin
                        if (can_add) begin
                            entry_bcd_d = shifted;
                            entry_len_d = entry_len_q + LEN_W'(1);
                        end
                    end else if (is_op && state_q == S_ENTER_A && has_digits) begin
                        op_a_d      = entry_bcd_q;
                        entry_bcd_d = '0;
                        entry_len_d = '0;
                        op_sel_d    = op_val;
                        state_d     = S_ENTER_B;
                    end else if (is_eq && state_q == S_ENTER_B && has_digits) begin
                        op_b_d  = entry_bcd_q;
                        start_d = 1'b1;
                        state_d = S_DONE;
                    end
                end
                S_DONE: begin
                    if (is_digit) begin
                        op_a_d      = '0;
                        op_b_d      = '0;
                        op_sel_d    = 1'b0;
                        entry_bcd_d = W'(digit);
                        entry_len_d = LEN_W'(1);
                        state_d     = S_ENTER_A;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_ENTER_A;
            held_q      <= 1'b0;
            cnt_q       <= '0;
            ev_q        <= 1'b0;
            code_q      <= 4'd0;
            entry_bcd_q <= '0;
            entry_len_q <= '0;
            op_a_q      <= '0;
            op_b_q      <= '0;
            op_sel_q    <= 1'b0;
            start_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            held_q      <= held_d;
            cnt_q       <= cnt_d;
            ev_q        <= ev_d;
            code_q      <= code_d;
            entry_bcd_q <= entry_bcd_d;
            entry_len_q <= entry_len_d;
            op_a_q      <= op_a_d;
            op_b_q      <= op_b_d;
            op_sel_q    <= op_sel_d;
            start_q     <= start_d;
        end
    end

    assign kif.entry_bcd = entry_bcd_q;
    assign kif.entry_len = entry_len_q;
    assign kif.op_a      = op_a_q;
    assign kif.op_b      = op_b_q;
    assign kif.op_sel    = op_sel_q;
    assign kif.phase     = state_q;
    assign kif.start     = start_q;
endmodule

// File: tb/tb_keypad_entry_ctrl.sv
// Bench for keypad_entry_ctrl: digit-list reference model checked every cycle, plus
// directed key sequences with literal expectations. Honours SUB_OP_EN like the DUT.
module tb_keypad_entry_ctrl;
    localparam int ND = 3;
    localparam int RC = 8;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    keypad_entry_if #(.N_DIGITS(ND)) kif ();
    keypad_entry_ctrl #(.N_DIGITS(ND), .RELEASE_CYCLES(RC)) dut (
        .clk(clk), .rst_n(rst_n), .kif(kif)
    );

    int n_chk  = 0;
    int n_fail = 0;
    int n_start = 0;

    // Key meaning by row*4+col: 0..9 digits, 10 = A, 11 = B, 12 = C, 13 = D, 14 = '*', 15 = '#'.
    int keymap [16] = '{1, 2, 3, 10, 4, 5, 6, 11, 7, 8, 9, 12, 14, 0, 15, 13};

    // Reference model: typed digits kept as a list, most significant first.
    int ent [$];
    int m_opa = 0, m_opb = 0, m_opsel = 0, m_phase = 0;
    bit m_start = 0, m_held = 0, m_pend = 0;
    int m_idle = 0, m_key = 0;

    function automatic logic [31:0] pack_digits(input int d [$]);
        logic [31:0] v = 0;
        foreach (d[i]) v = (v << 4) | 32'(d[i]);
        return v;
    endfunction

    function automatic bit is_operator(input int k);
`ifdef SUB_OP_EN
        return (k == 10) || (k == 11);
`else
        return k == 10;
`endif
    endfunction

    task automatic apply_key(input int k);
        if (k == 14) begin
            ent.delete(); m_opa = 0; m_opb = 0; m_opsel = 0; m_phase = 0;
        end else if (m_phase == 2) begin
            if (k <= 9) begin
                m_opa = 0; m_opb = 0; m_opsel = 0; ent.delete(); ent.push_back(k); m_phase = 0;
            end
        end else if (k <= 9) begin
            if (ent.size() < ND) ent.push_back(k);
        end else if (m_phase == 0 && is_operator(k) && ent.size() > 0) begin
            m_opa = int'(pack_digits(ent)); ent.delete();
            m_opsel = (k == 11) ? 1 : 0; m_phase = 1;
        end else if (m_phase == 1 && k == 15 && ent.size() > 0) begin
            m_opb = int'(pack_digits(ent)); m_start = 1; m_phase = 2;
        end
    endtask

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ent.delete(); m_opa = 0; m_opb = 0; m_opsel = 0; m_phase = 0;
            m_start = 0; m_held = 0; m_pend = 0; m_idle = 0;
        end else begin
            m_start = 0;
            if (m_pend) begin
                apply_key(m_key);
                m_pend = 0;
            end
            if (kif.key_valid) begin
                m_idle = 0;
                if (!m_held) begin
                    m_held = 1; m_pend = 1;
                    m_key = keymap[int'(kif.key_row) * 4 + int'(kif.key_col)];
                end
            end else if (m_held) begin
                m_idle++;
                if (m_idle == RC) begin m_held = 0; m_idle = 0; end
            end
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got %0h, expected %0h", name, $time, act, exp);
        end
    endtask

    always @(negedge clk) begin
        check("cyc_entry_bcd", 32'(kif.entry_bcd), pack_digits(ent));
        check("cyc_entry_len", 32'(kif.entry_len), 32'(ent.size()));
        check("cyc_op_a",      32'(kif.op_a),      32'(m_opa));
        check("cyc_op_b",      32'(kif.op_b),      32'(m_opb));
        check("cyc_op_sel",    32'(kif.op_sel),    32'(m_opsel));
        check("cyc_phase",     32'(kif.phase),     32'(m_phase));
        check("cyc_start",     32'(kif.start),     32'(m_start));
        if (kif.start === 1'b1) n_start++;
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic press(input int r, input int c);
        @(negedge clk);
        kif.key_valid = 1'b1; kif.key_row = 2'(r); kif.key_col = 2'(c);
        @(negedge clk);
        kif.key_valid = 1'b0;
        tick(12);
    endtask

    int s0;

    initial begin
        kif.key_valid = 1'b0; kif.key_row = 2'd0; kif.key_col = 2'd0;
        tick(3);
        check("rst_entry_bcd", 32'(kif.entry_bcd), 32'h0);
        check("rst_op_a",      32'(kif.op_a),      32'h0);
        check("rst_phase",     32'(kif.phase),     32'h0);
        rst_n = 1'b1;
        tick(5);
        check("idle_after_rst_len", 32'(kif.entry_len), 32'h0);

        // Bouncing reports of '1' at t=0,5,10: one event, visible two edges after the first.
        @(negedge clk); kif.key_valid = 1'b1;
        @(negedge clk); kif.key_valid = 1'b0;
        check("lat_t1_len", 32'(kif.entry_len), 32'h0);
        @(negedge clk);
        check("lat_t2_len", 32'(kif.entry_len), 32'h1);
        tick(2);
        @(negedge clk); kif.key_valid = 1'b1;
        @(negedge clk); kif.key_valid = 1'b0;
        tick(3);
        @(negedge clk); kif.key_valid = 1'b1;
        @(negedge clk); kif.key_valid = 1'b0;
        tick(20);
        check("bounce_bcd", 32'(kif.entry_bcd), 32'h001);
        check("bounce_len", 32'(kif.entry_len), 32'h1);
        press(3, 0);

        // 1,2,3,4: fourth digit dropped.
        press(0, 0); press(0, 1); press(0, 2); press(1, 0);
        check("full_bcd", 32'(kif.entry_bcd), 32'h123);
        check("full_len", 32'(kif.entry_len), 32'h3);
        press(3, 0);

        // 1,2,A,4,5,#
        s0 = n_start;
        press(0, 0); press(0, 1); press(0, 3); press(1, 0); press(1, 1); press(3, 2);
        check("calc_op_a",   32'(kif.op_a),   32'h012);
        check("calc_op_b",   32'(kif.op_b),   32'h045);
        check("calc_op_sel", 32'(kif.op_sel), 32'h0);
        check("calc_phase",  32'(kif.phase),  32'h2);
        check("calc_start_pulses", 32'(n_start - s0), 32'h1);
        check("calc_entry_bcd", 32'(kif.entry_bcd), 32'h045);
        press(2, 0);
        check("restart_phase", 32'(kif.phase),     32'h0);
        check("restart_bcd",   32'(kif.entry_bcd), 32'h007);
        check("restart_op_a",  32'(kif.op_a),      32'h0);
        press(3, 0);

        // Operator with nothing entered, then 9,A,3,*.
        press(0, 3);
        check("empty_op_phase", 32'(kif.phase), 32'h0);
        press(2, 2); press(0, 3); press(0, 2);
        check("pre_clr_phase", 32'(kif.phase), 32'h1);
        check("pre_clr_op_a",  32'(kif.op_a),  32'h009);
        press(3, 0);
        check("clr_phase", 32'(kif.phase),     32'h0);
        check("clr_bcd",   32'(kif.entry_bcd), 32'h0);
        check("clr_op_a",  32'(kif.op_a),      32'h0);

        // '5' then '6' three cycles later with no release gap.
        @(negedge clk); kif.key_valid = 1'b1; kif.key_row = 2'd1; kif.key_col = 2'd1;
        @(negedge clk); kif.key_valid = 1'b0;
        tick(1);
        @(negedge clk); kif.key_valid = 1'b1; kif.key_row = 2'd1; kif.key_col = 2'd2;
        @(negedge clk); kif.key_valid = 1'b0;
        tick(12);
        check("second_key_bcd", 32'(kif.entry_bcd), 32'h005);
        check("second_key_len", 32'(kif.entry_len), 32'h1);
        press(3, 0);

        // 8,B,2,#
        s0 = n_start;
        press(2, 1); press(1, 3); press(0, 1); press(3, 2);
`ifdef SUB_OP_EN
        check("sub_op_sel", 32'(kif.op_sel), 32'h1);
        check("sub_start_pulses", 32'(n_start - s0), 32'h1);
        check("sub_op_a",  32'(kif.op_a),  32'h008);
        check("sub_op_b",  32'(kif.op_b),  32'h002);
        check("sub_phase", 32'(kif.phase), 32'h2);
`else
        check("nosub_phase", 32'(kif.phase),     32'h0);
        check("nosub_bcd",   32'(kif.entry_bcd), 32'h082);
        check("nosub_start_pulses", 32'(n_start - s0), 32'h0);
        check("nosub_op_sel", 32'(kif.op_sel),   32'h0);
`endif
        press(3, 0);

        // Asynchronous reset mid-entry with key '3' held through reset release.
        press(0, 0);
        @(negedge clk); kif.key_valid = 1'b1; kif.key_row = 2'd0; kif.key_col = 2'd2;
        tick(2);
        #2 rst_n = 1'b0;
        #1;
        check("async_rst_bcd", 32'(kif.entry_bcd), 32'h0);
        check("async_rst_len", 32'(kif.entry_len), 32'h0);
        @(negedge clk);
        @(negedge clk); rst_n = 1'b1;
        tick(3);
        kif.key_valid = 1'b0;
        tick(12);
        check("held_thru_rst_bcd", 32'(kif.entry_bcd), 32'h003);
        check("held_thru_rst_len", 32'(kif.entry_len), 32'h1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
